// File: rtl/dm_pkg.sv
// Shared debug-module encodings: ROM routine selects, cmderr codes, command types
// and the debug ROM patch offsets for each routine.
package dm_pkg;

  typedef enum logic [2:0] {
    ROM_SET_GPR = 3'd0,
    ROM_GET_GPR = 3'd1,
    ROM_SET_CSR = 3'd2,
    ROM_GET_CSR = 3'd3,
    ROM_SET_MEM = 3'd4,
    ROM_GET_MEM = 3'd5
  } rom_sel_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BUSY    = 3'd1,
    ERR_NOT_SUP = 3'd2,
    ERR_EXC     = 3'd3,
    ERR_HALT    = 3'd4,
    ERR_OTHER   = 3'd7
  } cmderr_e;

  localparam logic [7:0] CMDTYPE_REG = 8'd0;
  localparam logic [7:0] CMDTYPE_MEM = 8'd2;

  localparam logic [11:0] OFS_SET_GPR = 12'h11C;
  localparam logic [11:0] OFS_GET_GPR = 12'h154;
  localparam logic [11:0] OFS_SET_CSR = 12'h17C;
  localparam logic [11:0] OFS_GET_CSR = 12'h1A0;
  localparam logic [11:0] OFS_SET_MEM = 12'h1C4;
  localparam logic [11:0] OFS_GET_MEM = 12'h1E0;

  // Where in the ROM the instr_fix field lands for a given routine.
  function automatic logic [11:0] rom_patch_ofs(input logic [2:0] sel);
    logic [11:0] ofs;
    case (sel)
      ROM_SET_GPR: ofs = OFS_SET_GPR;
      ROM_GET_GPR: ofs = OFS_GET_GPR;
      ROM_SET_CSR: ofs = OFS_SET_CSR;
      ROM_GET_CSR: ofs = OFS_GET_CSR;
      ROM_SET_MEM: ofs = OFS_SET_MEM;
      default:     ofs = OFS_GET_MEM;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/dm_abscmd_if.sv
// Debugger/hart-facing signals of the abstract command engine.
// master = debugger + hart side, slave = the command engine.
interface dm_abscmd_if;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic [2:0]  cmderr_clr;
  logic        hart_halted;
  logic        hart_ack;
  logic        hart_done;
  logic        hart_exc;
  logic        go;
  logic [2:0]  rom_sel;
  logic [11:0] instr_fix;
  logic        busy;
  logic [2:0]  cmderr;

  modport master (
    output cmd_valid, cmd_data, cmderr_clr, hart_halted, hart_ack, hart_done, hart_exc,
    input  go, rom_sel, instr_fix, busy, cmderr
  );

  modport slave (
    input  cmd_valid, cmd_data, cmderr_clr, hart_halted, hart_ack, hart_done, hart_exc,
    output go, rom_sel, instr_fix, busy, cmderr
  );
endinterface

// File: rtl/dm_cmd_decode.sv
// Purely combinational check of an abstract command word; yields either an error
// code, a start request with routine select + ROM patch, or neither (no-op command).
module dm_cmd_decode
  import dm_pkg::*;
(
  input  logic [31:0] cmd_data,
  input  logic        hart_halted,
  output logic [2:0]  err,
  output logic        start,
  output logic [2:0]  rom_sel,
  output logic [11:0] instr_fix
);

  logic [7:0]  cmdtype;
  logic [2:0]  sz;
  logic [15:0] regno;
  logic        is_gpr;
  logic        is_csr;

  assign cmdtype = cmd_data[31:24];
  assign sz      = cmd_data[22:20];
  assign regno   = cmd_data[15:0];
  assign is_gpr  = (regno[15:5] == 11'h080);
  assign is_csr  = (regno[15:12] == 4'h0);

  always_comb begin
    err       = ERR_NONE;
    start     = 1'b0;
    rom_sel   = ROM_SET_GPR;
    instr_fix = 12'h000;
    if (cmdtype != CMDTYPE_REG && cmdtype != CMDTYPE_MEM) begin
      err = ERR_NOT_SUP;
    end else if (cmd_data[18] || cmd_data[19]) begin
      err = ERR_NOT_SUP;
    end else if (cmdtype == CMDTYPE_REG && !cmd_data[17]) begin
      // register access without transfer: completes immediately, nothing to run
      err = ERR_NONE;
    end else if (cmdtype == CMDTYPE_REG && (sz != 3'd2 || !(is_gpr || is_csr))) begin
      err = ERR_NOT_SUP;
    end else if (cmdtype == CMDTYPE_MEM && (sz > 3'd2 || cmd_data[23])) begin
      err = ERR_NOT_SUP;
    end else if (!hart_halted) begin
      err = ERR_HALT;
    end else begin
      start = 1'b1;
      if (cmdtype == CMDTYPE_MEM) begin
        rom_sel   = cmd_data[16] ? ROM_SET_MEM : ROM_GET_MEM;
        instr_fix = {9'b0, sz};
      end else if (is_gpr) begin
        rom_sel   = cmd_data[16] ? ROM_SET_GPR : ROM_GET_GPR;
        instr_fix = {7'b0, regno[4:0]};
      end else begin
        rom_sel   = cmd_data[16] ? ROM_SET_CSR : ROM_GET_CSR;
        instr_fix = regno[11:0];
      end
    end
  end

endmodule

// File: rtl/dm_abscmd.sv
// Abstract command engine: IDLE -> GO (go raised, 1 cycle after accept) -> EXEC until
// the hart finishes, faults or the watchdog expires; sticky cmderr with set-beats-clear.
module dm_abscmd
  import dm_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  dm_abscmd_if.slave  bus
);

  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GO, S_EXEC} state_e;

  state_e          state_q, state_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [2:0]      cmderr_q, cmderr_d;
  logic [2:0]      rom_sel_q, rom_sel_d;
  logic [11:0]     fix_q, fix_d;
  logic            expired;

  logic [2:0]      dec_err;
  logic            dec_start;
  logic [2:0]      dec_rom_sel;
  logic [11:0]     dec_fix;

  dm_cmd_decode u_decode (
    .cmd_data    (bus.cmd_data),
    .hart_halted (bus.hart_halted),
    .err         (dec_err),
    .start       (dec_start),
    .rom_sel     (dec_rom_sel),
    .instr_fix   (dec_fix)
  );

  assign expired = (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    rom_sel_d = rom_sel_q;
    fix_d     = fix_q;
    cmderr_d  = cmderr_q & ~bus.cmderr_clr;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmderr_q == ERR_NONE) begin
          if (dec_err != ERR_NONE) begin
            cmderr_d = dec_err;
          end else if (dec_start) begin
            state_d   = S_GO;
            wdog_d    = '0;
            rom_sel_d = dec_rom_sel;
            fix_d     = dec_fix;
          end
        end
      end
      S_GO, S_EXEC: begin
        if (bus.cmd_valid && cmderr_q == ERR_NONE) cmderr_d = ERR_BUSY;
        wdog_d = wdog_q + 1'b1;
        // completion in EXEC wins over the watchdog; an ack on the last cycle does not
        if (state_q == S_EXEC && bus.hart_exc) begin
          state_d  = S_IDLE;
          cmderr_d = ERR_EXC;
        end else if (state_q == S_EXEC && bus.hart_done) begin
          state_d = S_IDLE;
        end else if (expired) begin
          state_d  = S_IDLE;
          cmderr_d = ERR_OTHER;
        end else if (state_q == S_GO && bus.hart_ack) begin
          state_d = S_EXEC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wdog_q    <= '0;
      cmderr_q  <= ERR_NONE;
      rom_sel_q <= ROM_SET_GPR;
      fix_q     <= 12'h000;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      cmderr_q  <= cmderr_d;
      rom_sel_q <= rom_sel_d;
      fix_q     <= fix_d;
    end
  end

  assign bus.go        = (state_q == S_GO);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cmderr    = cmderr_q;
  assign bus.rom_sel   = rom_sel_q;
  assign bus.instr_fix = fix_q;

endmodule

// File: doc/dm_abscmd.md
DM_ABSCMD -- requirements
Module: dm_abscmd

Interface
REQ-001 Parameter TIMEOUT, default 1024: cycles allowed from go assertion to hart_done or hart_exc.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  one-cycle strobe: debugger wrote the abstract command register.
REQ-005 cmd_data  input  32  command word: cmdtype[31:24], size[22:20], postincrement 19, postexec 18, transfer 17, write 16, regno[15:0].
REQ-006 cmderr_clr  input  3  write-1-to-clear mask for cmderr, sampled every cycle.
REQ-007 hart_halted  input  1  hart is in debug mode, parked in the ROM idle loop.
REQ-008 hart_ack  input  1  hart has observed go and entered the routine.
REQ-009 hart_done  input  1  hart finished the routine normally.
REQ-010 hart_exc  input  1  hart took an exception inside the routine.
REQ-011 go  output  1  flag polled by the ROM idle loop.
REQ-012 rom_sel  output  3  routine select: 0 SET_GPR, 1 GET_GPR, 2 SET_CSR, 3 GET_CSR, 4 SET_MEM, 5 GET_MEM.
REQ-013 instr_fix  output  12  patch field consumed by the debug ROM.
REQ-014 busy  output  1  abstract command in progress.
REQ-015 cmderr  output  3  sticky command error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume, 7 other (timeout).

Function
REQ-016 FSM states: IDLE, GO, EXEC. busy is high in GO and EXEC.
REQ-017 IDLE accepts cmd_valid only while cmderr==0; when cmderr!=0, cmd_valid is ignored with no state change.
REQ-018 Accepted command checks, in priority order:
  - cmdtype not 0 or 2 -> cmderr=2.
  - postexec=1 or postincrement=1 -> cmderr=2.
  - cmdtype 0, transfer=0 -> complete with no error, stay IDLE.
  - cmdtype 0: size!=2, or regno outside 0x0000-0x0FFF (CSR) and 0x1000-0x101F (GPR) -> cmderr=2.
  - cmdtype 2: size>2 or bit 23 (virtual)=1 -> cmderr=2.
  - hart_halted=0 -> cmderr=4.
  - otherwise -> latch rom_sel and instr_fix, go to GO next cycle.
REQ-019 instr_fix encoding:
  - GPR: {7'b0, regno[4:0]}.
  - CSR: regno[11:0].
  - MEM: {9'b0, size[2:0]}, used as funct3.
REQ-020 rom_sel encoding: write=1 selects a SET routine, write=0 a GET routine.
REQ-021 rom_sel and instr_fix hold their latched values until the next accepted command.
REQ-022 GO: go=1; hart_ack -> EXEC with go=0 on the following cycle.
REQ-023 EXEC: hart_done -> IDLE. hart_exc -> IDLE and cmderr=3. hart_exc takes priority when both assert in the same cycle.
REQ-024 Watchdog counter:
  - clears on entry to GO and increments each cycle in GO and EXEC.
  - on reaching TIMEOUT-1 without completion: go=0, cmderr=7, return to IDLE.
REQ-025 cmd_valid while busy -> cmderr=1 if cmderr==0. The running command continues unaffected.
REQ-026 cmderr update each cycle is (cmderr & ~cmderr_clr), then a newly raised error overwrites it in the same cycle (set beats clear).
REQ-027 hart_ack, hart_done and hart_exc are ignored in states that do not consume them.
REQ-028 The transition from IDLE to GO takes 1 cycle after cmd_valid; busy falls the cycle after hart_done.

Reset
REQ-029 On rst in any state (including mid-command), the next edge forces IDLE, go=0, busy=0, cmderr=0, rom_sel=0, instr_fix=0, and watchdog=0.

Structure
REQ-030 A shared package dm_pkg holds:
  - rom_sel codes and cmderr codes.
  - cmdtype values.
  - ROM patch offsets 0x11C, 0x154, 0x17C, 0x1A0, 0x1C4, 0x1E0.
REQ-031 Command checking and encoding live in one combinational sub-module, dm_cmd_decode. The FSM, watchdog and cmderr live in dm_abscmd.

Verification
REQ-032 halted, cmd_data=0x0023_1005 (GPR x5, SET) -> rom_sel=0, instr_fix=0x005, go high from cycle+1; ack then done -> busy=0, cmderr=0.
REQ-033 halted, cmd_data=0x0022_0341 (CSR mepc, GET) -> rom_sel=3, instr_fix=0x341; assert hart_exc and hart_done in the same cycle -> cmderr=3.
REQ-034 cmd_data=0x0201_0000 (MEM byte, SET) with hart_halted=0 -> cmderr=4, go never asserted; then cmderr_clr=7 -> cmderr=0.
REQ-035 Second cmd_valid during EXEC -> cmderr=1, first command still completes; a further cmd_valid while cmderr=1 is ignored.
REQ-036 TIMEOUT=16, hart never acks -> go drops and cmderr=7 after 16 cycles; rst asserted mid-EXEC -> all outputs 0 on the next edge.
